sync_r2w_status: RTL and testbench

//  Write-domain receiver for the async FIFO read pointer: parametrised N-stage Gray synchroniser

---
 rtl/sync_r2w_status.sv | 94 +++++++++
 tb/tb_sync_r2w_status.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/sync_r2w_status.sv
// Write-domain receiver for the async FIFO read pointer: Gray synchroniser,
// Gray-to-binary conversion and write-side status (fill level, full, almost_full, Gray-step error).
module sync_r2w_status #(
  parameter int ADDR_W       = 5,
  parameter int SYNC_STAGES  = 2,
  parameter int AFULL_THRESH = 28
) (
  input  logic              wr_clk,
  input  logic              wr_rst_n,
  input  logic [ADDR_W:0]   rd_ptr,
  input  logic [ADDR_W:0]   wr_ptr_next,
  input  logic              clr_err,
  output logic [ADDR_W:0]   wq2_rd_ptr,
  output logic [ADDR_W:0]   wq_rd_bin,
  output logic              rd_moved,
  output logic [ADDR_W:0]   fill_level,
  output logic              full,
  output logic              almost_full,
  output logic              gray_err
);

  localparam int PW = ADDR_W + 1;
  localparam logic [ADDR_W:0] FULL_LVL  = PW'(2 ** ADDR_W);
  localparam logic [ADDR_W:0] AFULL_LVL = PW'(AFULL_THRESH);

  generate
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_stages
      $error("sync_r2w_status: SYNC_STAGES must be in 2..4");
    end
    if (AFULL_THRESH < 1 || AFULL_THRESH > 2 ** ADDR_W) begin : g_bad_thresh
      $error("sync_r2w_status: AFULL_THRESH must be in 1..2**ADDR_W");
    end
  endgenerate

  logic [SYNC_STAGES-1:0][ADDR_W:0] sync_reg;
  logic [ADDR_W:0] prev_reg;
  logic [ADDR_W:0] rd_bin_next;
  logic [ADDR_W:0] step_diff;
  logic            multi_step;
  logic [ADDR_W:0] lvl;

  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      sync_reg <= '0;
    end else begin
      sync_reg[0] <= rd_ptr;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_reg[i] <= sync_reg[i-1];
      end
    end
  end

  assign wq2_rd_ptr = sync_reg[SYNC_STAGES-1];

  // Binary bit i is the XOR of all Gray bits at or above i.
  genvar gi;
  generate
    for (gi = 0; gi < PW; gi++) begin : g_gray2bin
      assign rd_bin_next[gi] = ^(wq2_rd_ptr >> gi);
    end
  endgenerate

  // A legal Gray step flips at most one bit: diff & (diff-1) clears the lowest set bit.
  assign step_diff  = wq2_rd_ptr ^ prev_reg;
  assign multi_step = |(step_diff & (step_diff - PW'(1)));

  // Uses the previous cycle's binary pointer: status lags, so full can only release late.
  assign lvl = wr_ptr_next - wq_rd_bin;

  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      prev_reg    <= '0;
      rd_moved    <= 1'b0;
      wq_rd_bin   <= '0;
      fill_level  <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
      gray_err    <= 1'b0;
    end else begin
      prev_reg    <= wq2_rd_ptr;
      rd_moved    <= (wq2_rd_ptr != prev_reg);
      wq_rd_bin   <= rd_bin_next;
      fill_level  <= lvl;
      full        <= (lvl == FULL_LVL);
      almost_full <= (lvl >= AFULL_LVL);
      if (multi_step) begin
        gray_err <= 1'b1;
      end else if (clr_err) begin
        gray_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sync_r2w_status.sv
// Randomised and directed bench for sync_r2w_status: a driver pushes per-edge expectations
// from a delay-line/lookup-table model, a monitor pops and compares after every edge.
module tb_sync_r2w_status;
  localparam int ADDR_W = 5;
  localparam int S      = 2;
  localparam int THR    = 28;
  localparam int PW     = ADDR_W + 1;
  localparam int DEPTH  = 2 ** ADDR_W;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [PW-1:0] rd_ptr = '0;
  logic [PW-1:0] wr_ptr_next = '0;
  logic          clr_err = 1'b0;
  logic [PW-1:0] wq2_rd_ptr, wq_rd_bin, fill_level;
  logic          rd_moved, full, almost_full, gray_err;

  sync_r2w_status #(.ADDR_W(ADDR_W), .SYNC_STAGES(S), .AFULL_THRESH(THR)) dut (
    .wr_clk(clk), .wr_rst_n(rst_n), .rd_ptr(rd_ptr), .wr_ptr_next(wr_ptr_next),
    .clr_err(clr_err), .wq2_rd_ptr(wq2_rd_ptr), .wq_rd_bin(wq_rd_bin), .rd_moved(rd_moved),
    .fill_level(fill_level), .full(full), .almost_full(almost_full), .gray_err(gray_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int wq2, bin, fill, mv, fl, af, err;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_txn    = 0;

  // Reference model: delay line of sampled pointers, Gray decode by lookup table.
  int gray2bin_tab[64];
  int pipe[$];
  int m_prev, m_bin, m_err;

  function automatic int gray_of(input int b);
    return (b ^ (b >> 1)) & (2 ** PW - 1);
  endfunction

  function automatic void model_reset();
    pipe.delete();
    for (int i = 0; i < S; i++) pipe.push_back(0);
    m_prev = 0;
    m_bin  = 0;
    m_err  = 0;
  endfunction

  function automatic void model_step(input int rd, input int wrn, input int clr);
    exp_t e;
    int   old_wq2, lvl;
    old_wq2 = pipe[S-1];
    e.mv    = (old_wq2 != m_prev) ? 1 : 0;
    e.err   = ($countones(old_wq2 ^ m_prev) > 1) ? 1 : ((m_err != 0 && clr == 0) ? 1 : 0);
    e.bin   = gray2bin_tab[old_wq2];
    lvl     = (wrn - m_bin) % (2 ** PW);
    if (lvl < 0) lvl += 2 ** PW;
    e.fill  = lvl;
    e.fl    = (lvl == DEPTH) ? 1 : 0;
    e.af    = (lvl >= THR) ? 1 : 0;
    pipe.push_front(rd);
    void'(pipe.pop_back());
    e.wq2   = pipe[S-1];
    m_prev  = old_wq2;
    m_bin   = e.bin;
    m_err   = e.err;
    exp_q.push_back(e);
  endfunction

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_wq2"}, int'(wq2_rd_ptr), 0);
    chk({tag, "_bin"}, int'(wq_rd_bin), 0);
    chk({tag, "_mv"}, int'(rd_moved), 0);
    chk({tag, "_fill"}, int'(fill_level), 0);
    chk({tag, "_full"}, int'(full), 0);
    chk({tag, "_afull"}, int'(almost_full), 0);
    chk({tag, "_err"}, int'(gray_err), 0);
  endtask

  task automatic cyc(input int rd, input int wrn, input int clr);
    @(negedge clk);
    rd_ptr      = PW'(rd);
    wr_ptr_next = PW'(wrn);
    clr_err     = (clr != 0);
    if (rst_n) model_step(rd, wrn, clr);
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst_n = 1'b1;
    model_step(int'(rd_ptr), int'(wr_ptr_next), int'(clr_err));
  endtask

  // Monitor: every edge out of reset carries one expected output set.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_txn++;
        $display("txn %0d: wq2=%h bin=%h fill=%0d full=%b afull=%b moved=%b err=%b",
                 n_txn, wq2_rd_ptr, wq_rd_bin, fill_level, full, almost_full, rd_moved, gray_err);
        chk("wq2_rd_ptr", int'(wq2_rd_ptr), e.wq2);
        chk("wq_rd_bin", int'(wq_rd_bin), e.bin);
        chk("fill_level", int'(fill_level), e.fill);
        chk("full", int'(full), e.fl);
        chk("almost_full", int'(almost_full), e.af);
        chk("rd_moved", int'(rd_moved), e.mv);
        chk("gray_err", int'(gray_err), e.err);
      end
    end
  end

  initial begin
    int rb, r;
    for (int b = 0; b < 64; b++) gray2bin_tab[gray_of(b)] = b;
    model_reset();

    // Reset held with a non-zero pointer on the input.
    rd_ptr = 6'h15;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk_zero("rst_hold");
    end
    release_rst();
    for (int i = 0; i < 4; i++) cyc(6'h15, 0, 0);
    cyc(6'h15, 0, 1);
    for (int i = 0; i < 3; i++) cyc(6'h00, 0, 0);
    cyc(6'h00, 0, 1);

    // Single-step latency 0 -> 1.
    for (int i = 0; i < 5; i++) cyc(6'h01, 1, 0);

    // Full and below almost_full.
    for (int i = 0; i < 4; i++) cyc(6'h00, 32, 0);
    for (int i = 0; i < 3; i++) cyc(6'h00, 27, 0);
    for (int i = 0; i < 3; i++) cyc(6'h00, 28, 0);

    // Wrap-around: Gray 6'h20 is binary 63.
    for (int i = 0; i < 5; i++) cyc(6'h20, 31, 0);
    for (int i = 0; i < 5; i++) cyc(6'h00, 31, 0);

    // Gray error, clear, and clear coinciding with a new violation.
    cyc(6'h00, 0, 1);
    for (int i = 0; i < 3; i++) cyc(6'h00, 0, 0);
    for (int i = 0; i < 4; i++) cyc(6'h07, 5, 0);
    cyc(6'h07, 5, 1);
    for (int i = 0; i < 3; i++) cyc(6'h07, 5, 0);
    for (int i = 0; i < 4; i++) cyc(6'h18, 5, 1);
    for (int i = 0; i < 2; i++) cyc(6'h18, 5, 0);

    // Random walk of a legal read pointer with occasional jumps and clears.
    rb = 16;
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 99);
      if (r < 55) rb = rb;
      else if (r < 95) rb = rb + 1;
      else rb = $urandom_range(0, 63);
      rb = rb & 63;
      cyc(gray_of(rb), (rb + $urandom_range(0, 34)) & 63, ($urandom_range(0, 15) == 0) ? 1 : 0);
    end

    // Build full=1 and gray_err=1, then reset asynchronously between edges.
    for (int i = 0; i < 4; i++) cyc(6'h00, 32, 0);
    for (int i = 0; i < 4; i++) cyc(6'h07, 37, 0);
    @(posedge clk);
    #2;
    chk("pre_rst_full", int'(full), 1);
    chk("pre_rst_err", int'(gray_err), 1);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk_zero("async_rst");
    @(posedge clk);
    #1;
    chk_zero("async_rst_hold");
    release_rst();
    for (int i = 0; i < 6; i++) cyc(6'h07, 10, 0);

    @(posedge clk);
    #2;
    chk("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
